rr_decode_sequencer: RTL and testbench
======================================

Name: rr_decode_sequencer

Overview:
- Four-way round-robin request sequencer that drives the select and enable inputs of the 2-to-4 active-low decoder stage.
- Accepts four active-high requests and picks one winner at a time.
- Presents the winner as a 2-bit index {sel_a, sel_b} with an active-low enable, so exactly one decoder output goes low per grant.
- Inserts a guaranteed dead cycle between grants so decoder outputs never overlap.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles a single grant may stay active. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  active-high requests; bit i requests decoder output i
- done  input  1  single-cycle pulse: current owner releases its grant
- sel_a  output  1  index MSB, to decoder A
- sel_b  output  1  index LSB, to decoder B
- enable_n  output  1  active-low decoder enable; 0 = grant valid
- busy  output  1  high while in GRANT state
- ptr  output  2  current round-robin search start index (debug/observability)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values (asserted asynchronously, held while rst_n=0):
  - sel_a=0, sel_b=0, enable_n=1, busy=0, ptr=0
  - hold counter=0, state=IDLE
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, GRANT, GAP.
- Arbitration function: scan req starting at index ptr, ascending mod 4 (ptr, ptr+1, ptr+2, ptr+3). The first set bit wins.
- IDLE:
  - If req==0: stay, enable_n=1, busy=0.
  - Else, at the next edge: {sel_a,sel_b}=winner, enable_n=0, busy=1, hold counter=0, state=GRANT.
  - Latency: req high at edge k means the grant is visible immediately after edge k (one cycle from req set-up).
- GRANT:
  - sel and enable_n are frozen.
  - The hold counter increments each cycle, width 8 bits, saturating not required.
  - Release when any of these holds at an edge:
    - req[owner]==0
    - done==1
    - hold counter==MAX_HOLD-1
  - On release, at that edge: enable_n=1, busy=0, ptr=owner+1 mod 4, state=GAP. sel_a/sel_b hold their last value.
  - Several release conditions in the same cycle produce exactly one release and one ptr advance.
  - Changes on non-owner req bits during GRANT are ignored.
  - done while in IDLE or GAP is ignored.
- GAP:
  - Exactly one cycle with enable_n=1.
  - At its ending edge, apply the IDLE arbitration using the updated ptr: go to GRANT if any req is set, else go to IDLE.
  - Consecutive grants are therefore separated by exactly one enable_n=1 cycle.
- Grant length: with MAX_HOLD=1, every grant lasts exactly one cycle. With MAX_HOLD=N and the request held, the grant lasts exactly N cycles.
- Fairness: a requester that stays asserted is granted within 3 grants of any other requester.
- Reset mid-grant: enable_n goes to 1 asynchronously, without waiting for clk. ptr returns to 0. The first post-reset arbitration restarts from index 0.
- Downstream contract: the decoder output indexed by {sel_a,sel_b} is low exactly while enable_n=0. All four outputs are high during IDLE, GAP and reset.

Test Plan:
- Reset then req=4'b0000 for 10 cycles: enable_n=1, busy=0, sel=00, ptr=00 throughout.
- From reset, req=4'b0100 held, MAX_HOLD=8:
  - One cycle after the sampling edge, sel=10, enable_n=0.
  - The grant lasts 8 cycles, then one GAP cycle with ptr=11.
  - The grant is then re-issued to index 2 (the only requester).
- req=4'b1111 held, MAX_HOLD=2: grant order 0,1,2,3,0, each 2 cycles with enable_n low and 1 cycle high between grants.
- Grant owner 1, then assert done and drop req[1] in the same cycle: a single release, ptr=10, exactly one GAP cycle, no double advance.
- Grant active on index 3, pull rst_n low between clock edges: enable_n=1 immediately (before the next edge). After release, req=4'b1001 grants index 0 first.
- While owner 0 is granted, toggle req[2] on and off every cycle: sel and enable_n stay stable until owner 0 releases. Index 2 is granted next only if req[2]=1 at the GAP edge.

Source files
------------

// File: rtl/rr_decode_sequencer.sv
// Four-way round-robin sequencer driving a 2-to-4 active-low decoder: one grant at a time,
// each grant followed by a single dead cycle so decoder outputs never overlap.
module rr_decode_sequencer #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       sel_a,
    output logic       sel_b,
    output logic       enable_n,
    output logic       busy,
    output logic [1:0] ptr
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic       en_n_q, en_n_d;
    logic       busy_q, busy_d;
    logic [7:0] hold_q, hold_d;

    logic [2:0] win;
    logic       release_c;

    // Returns {found, index}; descending scan so the smallest offset from start wins.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign win       = pick(req, ptr_q);
    assign release_c = !req[sel_q] || done || (hold_q == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            en_n_q  <= en_n_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        en_n_d  = en_n_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (win[2]) begin
                    state_d = S_GRANT;
                    sel_d   = win[1:0];
                    en_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    hold_d  = 8'd0;
                end else begin
                    state_d = S_IDLE;
                    en_n_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_GRANT: begin
                // Any combination of release causes yields a single release and one ptr step.
                if (release_c) begin
                    state_d = S_GAP;
                    en_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sel_a    = sel_q[1];
    assign sel_b    = sel_q[0];
    assign enable_n = en_n_q;
    assign busy     = busy_q;
    assign ptr      = ptr_q;

endmodule

// File: tb/tb_rr_decode_sequencer.sv
// Directed bench for rr_decode_sequencer: a MAX_HOLD=8 instance for the hand-written
// sequences and a MAX_HOLD=2 instance driven from a vector table.
module tb_rr_decode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req8 = '0, req2 = '0;
    logic       done8 = 1'b0, done2 = 1'b0;
    logic       s8a, s8b, e8, b8, s2a, s2b, e2, b2;
    logic [1:0] p8, p2;
    logic [5:0] o8, o2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_decode_sequencer #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .done(done8),
        .sel_a(s8a), .sel_b(s8b), .enable_n(e8), .busy(b8), .ptr(p8)
    );

    rr_decode_sequencer #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .done(done2),
        .sel_a(s2a), .sel_b(s2b), .enable_n(e2), .busy(b2), .ptr(p2)
    );

    // Observed outputs packed as {sel_a, sel_b, enable_n, busy, ptr}
    assign o8 = {s8a, s8b, e8, b8, p8};
    assign o2 = {s2a, s2b, e2, b2, p2};

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {sel,en_n,busy,ptr}=%b want %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req8 = '0; done8 = 1'b0; req2 = '0; done2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Round-robin over all four with MAX_HOLD=2, then done-driven early releases
        tbl[0]  = '{4'b1111, 1'b0, 6'b00_0_1_00};
        tbl[1]  = '{4'b1111, 1'b0, 6'b00_0_1_00};
        tbl[2]  = '{4'b1111, 1'b0, 6'b00_1_0_01};
        tbl[3]  = '{4'b1111, 1'b0, 6'b01_0_1_01};
        tbl[4]  = '{4'b1111, 1'b0, 6'b01_0_1_01};
        tbl[5]  = '{4'b1111, 1'b0, 6'b01_1_0_10};
        tbl[6]  = '{4'b1111, 1'b0, 6'b10_0_1_10};
        tbl[7]  = '{4'b1111, 1'b0, 6'b10_0_1_10};
        tbl[8]  = '{4'b1111, 1'b0, 6'b10_1_0_11};
        tbl[9]  = '{4'b1111, 1'b0, 6'b11_0_1_11};
        tbl[10] = '{4'b1111, 1'b0, 6'b11_0_1_11};
        tbl[11] = '{4'b1111, 1'b0, 6'b11_1_0_00};
        tbl[12] = '{4'b1111, 1'b0, 6'b00_0_1_00};
        tbl[13] = '{4'b1111, 1'b0, 6'b00_0_1_00};
        tbl[14] = '{4'b1111, 1'b1, 6'b00_1_0_01};
        tbl[15] = '{4'b1111, 1'b1, 6'b01_0_1_01};
        tbl[16] = '{4'b1111, 1'b1, 6'b01_1_0_10};
        tbl[17] = '{4'b0000, 1'b0, 6'b01_1_0_10};
        tbl[18] = '{4'b0000, 1'b0, 6'b01_1_0_10};
        tbl[19] = '{4'b0001, 1'b0, 6'b00_0_1_10};

        // Reset state while rst_n is held low
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dut8", o8, 6'b00_1_0_00);
        chk("reset_dut2", o2, 6'b00_1_0_00);
        rst_n = 1'b1;

        // No requests: stays idle
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle_%0d", i), o8, 6'b00_1_0_00);
        end

        // Single requester 2 with MAX_HOLD=8: 8-cycle grant, one gap, re-grant
        req8 = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("hold8_grant_%0d", i), o8, 6'b10_0_1_00);
        end
        step();
        chk("hold8_gap", o8, 6'b10_1_0_11);
        step();
        chk("hold8_regrant", o8, 6'b10_0_1_11);
        req8 = 4'b0000;
        step();
        chk("hold8_drop", o8, 6'b10_1_0_11);
        step();
        chk("hold8_idle", o8, 6'b10_1_0_11);

        // Table-driven MAX_HOLD=2 vectors
        do_reset();
        for (int i = 0; i < 20; i++) begin
            req2  = tbl[i].req;
            done2 = tbl[i].done;
            step();
            chk($sformatf("tbl_%0d", i), o2, tbl[i].exp);
        end
        req2 = '0; done2 = 1'b0;

        // Owner 1 releases with done and req drop together: single ptr advance
        do_reset();
        req8 = 4'b0010;
        step();
        chk("dbl_grant1", o8, 6'b01_0_1_00);
        req8 = 4'b0000; done8 = 1'b1;
        step();
        chk("dbl_release", o8, 6'b01_1_0_10);
        req8 = 4'b0010; done8 = 1'b0;
        step();
        chk("dbl_regrant", o8, 6'b01_0_1_10);
        req8 = 4'b0000;
        step();
        chk("dbl_release2", o8, 6'b01_1_0_10);

        // Non-owner req[2] toggling during owner 0 grant is ignored
        do_reset();
        req8 = 4'b0001;
        step();
        chk("tog_grant0", o8, 6'b00_0_1_00);
        for (int i = 0; i < 5; i++) begin
            req8 = (i % 2 == 0) ? 4'b0101 : 4'b0001;
            step();
            chk($sformatf("tog_stable_%0d", i), o8, 6'b00_0_1_00);
        end
        req8 = 4'b0100;
        step();
        chk("tog_release", o8, 6'b00_1_0_01);
        step();
        chk("tog_grant2", o8, 6'b10_0_1_01);
        req8 = 4'b0000;
        step();
        chk("tog_release2", o8, 6'b10_1_0_11);
        step();
        chk("tog_idle", o8, 6'b10_1_0_11);

        // Asynchronous reset in the middle of a grant to index 3
        do_reset();
        req8 = 4'b1000;
        step();
        chk("arst_grant3", o8, 6'b11_0_1_00);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_async", o8, 6'b00_1_0_00);
        #2;
        rst_n = 1'b1;
        req8 = 4'b1001;
        step();
        chk("arst_restart0", o8, 6'b00_0_1_00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
